// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer
// Command-driven sequencer for a universal shift register. Accepts READ,
// SHL, SHR and CLR commands, drives sel/serial_in for the required number
// of cycles, captures the parallel output and returns it as a response.
//
// Optional feature, enabled by defining USR_SEQ_ROTATE_EN:
//   cmd_rot=1 with SHL/SHR feeds serial_in from the register's own MSB/LSB
//   (rotate) instead of from cmd_data. Without the macro cmd_rot is ignored.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid and its payload stable until that edge; ready
// may be asserted independently of valid. cmd_ready is high only in IDLE,
// rsp_valid is high only in RESP, and rsp_data is stable while rsp_valid.
module usr_shift_sequencer #(
  parameter int WIDTH   = 4,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  input  logic               cmd_rot,
  output logic [1:0]         sr_sel,
  output logic               sr_serial_in,
  input  logic [WIDTH-1:0]   sr_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

  state_t               state, state_d;
  logic [1:0]           op_q, op_d;
  logic [MAX_LEN-1:0]   buf_q, buf_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 rot_q, rot_d;
  logic [WIDTH-1:0]     rsp_q, rsp_d;
  logic [LEN_W-1:0]     len_clamped;
  logic                 cmd_fire;

`ifndef USR_SEQ_ROTATE_EN
  // cmd_rot has no effect in this build.
  logic unused_cmd_rot;
  assign unused_cmd_rot = cmd_rot;
`endif

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign len_clamped = (cmd_len > MAX_LEN_C) ? MAX_LEN_C : cmd_len;

  // Output decode purely from registered state (serial_in may also look at
  // sr_out when rotating).
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_data  = rsp_q;
  assign sr_sel    = (state == S_SHIFT) ? op_q : 2'b00;

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      op_q  <= OP_READ;
      buf_q <= '0;
      cnt_q <= '0;
      rot_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      state <= state_d;
      op_q  <= op_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      rot_q <= rot_d;
      rsp_q <= rsp_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state;
    op_d    = op_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    rsp_d   = rsp_q;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          op_d  = cmd_op;
          buf_d = cmd_data;
`ifdef USR_SEQ_ROTATE_EN
          rot_d = cmd_rot && ((cmd_op == OP_SHL) || (cmd_op == OP_SHR));
`else
          rot_d = 1'b0;
`endif
          case (cmd_op)
            OP_SHL, OP_SHR: begin
              cnt_d   = len_clamped;
              state_d = (len_clamped == '0) ? S_CAPTURE : S_SHIFT;
            end
            OP_CLR: begin
              cnt_d   = ONE_C;
              state_d = S_SHIFT;
            end
            default: begin
              cnt_d   = '0;
              state_d = S_CAPTURE;
            end
          endcase
        end
      end
      S_SHIFT: begin
        buf_d = buf_q >> 1;
        // cnt is at least 1 in SHIFT, so the decrement never wraps.
        cnt_d = cnt_q - ONE_C;
        if (cnt_q <= ONE_C) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // sr_out already reflects the last shift edge.
        rsp_d   = sr_out;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Serial bit toward the register: buffered command data, or rotate feedback.
  always_comb begin
    sr_serial_in = 1'b0;
    if ((state == S_SHIFT) && (op_q != OP_CLR)) begin
`ifdef USR_SEQ_ROTATE_EN
      if (rot_q) begin
        sr_serial_in = (op_q == OP_SHL) ? sr_out[WIDTH-1] : sr_out[0];
      end else begin
        sr_serial_in = buf_q[0];
      end
`else
      sr_serial_in = buf_q[0];
`endif
    end
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Testbench for usr_shift_sequencer: behavioural 4-bit universal shift
// register, table of commands with expected results, reset-abort sequence
// and a short random phase checked against a reference function.
module tb_usr_shift_sequencer;

  localparam int WIDTH   = 4;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

`ifdef USR_SEQ_ROTATE_EN
  localparam logic [3:0] EXP_ROT_SHL = 4'hB;
  localparam logic [3:0] EXP_ROT_SHR = 4'hB;
  localparam logic [3:0] EXP_ABORT   = 4'h7;
`else
  localparam logic [3:0] EXP_ROT_SHL = 4'hA;
  localparam logic [3:0] EXP_ROT_SHR = 4'h0;
  localparam logic [3:0] EXP_ABORT   = 4'h1;
`endif

  logic               clk;
  logic               reset;
  logic               reg_rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               cmd_rot;
  logic [1:0]         sr_sel;
  logic               sr_serial_in;
  logic [WIDTH-1:0]   sr_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               busy;

  logic [WIDTH-1:0]   sr_q;
  logic [WIDTH-1:0]   exp_q[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 sel_total = 0;
  int                 sel_wrong = 0;
  logic [1:0]         exp_sel = 2'b00;

  typedef struct {
    logic [1:0] op;
    logic [3:0] len;
    logic [7:0] data;
    logic       rot;
    logic [3:0] exp_data;
    int         exp_cyc;
    int         exp_lat;
    int         hold;
  } vec_t;

  vec_t vecs[11];

  usr_shift_sequencer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_len      (cmd_len),
    .cmd_data     (cmd_data),
    .cmd_rot      (cmd_rot),
    .sr_sel       (sr_sel),
    .sr_serial_in (sr_serial_in),
    .sr_out       (sr_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy)
  );

  // Clock and register model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural universal shift register: 00 hold, 01 SHL, 10 SHR, 11 clear.
  always_ff @(posedge clk or negedge reg_rst_n) begin
    if (!reg_rst_n) sr_q <= '0;
    else begin
      case (sr_sel)
        2'b01:   sr_q <= {sr_q[WIDTH-2:0], sr_serial_in};
        2'b10:   sr_q <= {sr_serial_in, sr_q[WIDTH-1:1]};
        2'b11:   sr_q <= '0;
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign sr_out = sr_q;

  // Count active sel cycles and ones carrying the wrong opcode.
  always @(negedge clk) begin
    if (sr_sel != 2'b00) sel_total++;
    if (sr_sel != 2'b00 && sr_sel != exp_sel) sel_wrong++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop the oldest expected response and compare.
  task automatic check_rsp(input string name);
    logic [WIDTH-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: response %0h with empty expected queue", name, rsp_data);
    end else begin
      e = exp_q.pop_front();
      if (rsp_data !== e) begin
        errors++;
        $display("FAIL %s: rsp_data %0h expected %0h", name, rsp_data, e);
      end
    end
  endtask

  // Reference effect of one command on the register value.
  function automatic logic [3:0] ref_apply(input logic [3:0] v, input logic [1:0] op,
                                           input logic [3:0] len, input logic [7:0] d,
                                           output int cyc);
    int n;
    logic [3:0] r;
    r = v;
    cyc = 0;
    case (op)
      2'b11: begin r = 4'h0; cyc = 1; end
      2'b01, 2'b10: begin
        n = (len > 4'd8) ? 8 : int'(len);
        for (int i = 0; i < n; i++) begin
          if (op == 2'b01) r = {r[2:0], d[i]};
          else             r = {d[i], r[3:1]};
        end
        cyc = n;
      end
      default: cyc = 0;
    endcase
    return r;
  endfunction

  // Driver: called just after a rising edge with the DUT idle.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] len,
                         input logic [7:0] data, input logic rot, input logic [3:0] exp_data,
                         input int exp_cyc, input int exp_lat, input int hold);
    int lat;
    int s0;
    int w0;
    bit got;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_rot   = rot;
    cmd_valid = 1'b1;
    exp_sel   = op;
    exp_q.push_back(exp_data);
    @(negedge clk);
    check({name, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    s0 = sel_total;
    w0 = sel_wrong;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({name, "_busy"}, 32'(busy), 32'd1);
        check({name, "_cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
      end
      if (rsp_valid) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no rsp_valid after %0d cycles, required within 40", name, lat);
      return;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_sel_cycles"}, 32'(sel_total - s0), 32'(exp_cyc));
    check({name, "_sel_value"}, 32'(sel_wrong - w0), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({name, "_hold_data"}, 32'(rsp_data), 32'(exp_data));
      check({name, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    check_rsp({name, "_rsp_data"});
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] cur;
    logic [3:0] e;
    logic [1:0] rop;
    logic [3:0] rlen;
    logic [7:0] rdata;
    int         cyc;

    //                op     len    data   rot   exp    cyc lat hold
    vecs[0]  = '{2'b01, 4'd4,  8'h0B, 1'b0, 4'hD, 4, 6,  0};
    vecs[1]  = '{2'b10, 4'd2,  8'h01, 1'b0, 4'h7, 2, 4,  3};
    vecs[2]  = '{2'b11, 4'd5,  8'hFF, 1'b0, 4'h0, 1, 3,  0};
    vecs[3]  = '{2'b00, 4'd7,  8'hFF, 1'b0, 4'h0, 0, 2,  0};
    vecs[4]  = '{2'b01, 4'd12, 8'hFF, 1'b0, 4'hF, 8, 10, 0};
    vecs[5]  = '{2'b01, 4'd0,  8'hFF, 1'b0, 4'hF, 0, 2,  0};
    vecs[6]  = '{2'b10, 4'd3,  8'h02, 1'b0, 4'h5, 3, 5,  0};
    vecs[7]  = '{2'b01, 4'd8,  8'hA5, 1'b0, 4'h5, 8, 10, 0};
    vecs[8]  = '{2'b10, 4'd4,  8'h0D, 1'b0, 4'hD, 4, 6,  0};
    vecs[9]  = '{2'b01, 4'd1,  8'h00, 1'b1, EXP_ROT_SHL, 1, 3, 0};
    vecs[10] = '{2'b10, 4'd4,  8'h00, 1'b1, EXP_ROT_SHR, 4, 6, 0};

    // Reset phase
    reset     = 1'b0;
    reg_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = '0;
    cmd_data  = '0;
    cmd_rot   = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_sr_sel", 32'(sr_sel), 32'd0);
    check("rst_serial_in", 32'(sr_serial_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    reg_rst_n = 1'b1;

    // Table-driven commands
    for (int i = 0; i < 11; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].rot,
              vecs[i].exp_data, vecs[i].exp_cyc, vecs[i].exp_lat, vecs[i].hold);
    end

    // Reset during SHIFT: abort after one shift edge, register keeps its value.
    cmd_op    = 2'b01;
    cmd_len   = 4'd8;
    cmd_data  = 8'hFF;
    cmd_rot   = 1'b0;
    exp_sel   = 2'b01;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_sel_before", 32'(sr_sel), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_sr_sel", 32'(sr_sel), 32'd0);
    check("abort_serial_in", 32'(sr_serial_in), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    run_cmd("abort_read", 2'b00, 4'd3, 8'h55, 1'b0, EXP_ABORT, 0, 2, 0);

    // Random commands checked against the reference function.
    cur = EXP_ABORT;
    for (int i = 0; i < 8; i++) begin
      rop   = 2'($urandom_range(0, 3));
      rlen  = 4'($urandom_range(0, 12));
      rdata = 8'($urandom_range(0, 255));
      e = ref_apply(cur, rop, rlen, rdata, cyc);
      run_cmd($sformatf("rnd%0d", i), rop, rlen, rdata, 1'b0, e, cyc,
              (cyc == 0) ? 2 : cyc + 2, int'($urandom_range(0, 2)));
      cur = e;
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
